per2axi_req_arbiter: RTL

- Shares the single per2axi peripheral request port between NB_REQ cluster requesters.
- Round-robin arbitration with grant-stable locking.
- Per-requester outstanding-transaction limit.
- Atomic serialisation: an atomic request issues only when the port is drained, and no other request issues until its response returns.
- Sits between the cluster peripheral interconnect and per2axi_req_channel; it consumes response retire pulses from the per2axi response side.

---
 rtl/per2axi_pkg.sv | 21 ++
 rtl/per2axi_rr_arb.sv | 36 +++
 rtl/per2axi_req_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/per2axi_pkg.sv
// Shared types and helpers for the per2axi request arbitration and ID handling.
package per2axi_pkg;

    typedef enum logic {
        IDLE,
        ATOMIC
    } arb_state_e;

    localparam int ATOP_VALID_BIT = 5;

    // Index of the highest set bit; callers pass a one-hot value.
    function automatic int unsigned onehot2bin(input logic [31:0] onehot);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (onehot[i]) idx = int'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/per2axi_rr_arb.sv
// Round-robin pick over an eligibility vector, with a forced winner while locked.
module per2axi_rr_arb #(
    parameter int NB_REQ = 4,
    parameter int IDX_W  = 2
) (
    input  logic [NB_REQ-1:0] elig_i,
    input  logic [IDX_W-1:0]  rr_ptr_i,
    input  logic              lock_i,
    input  logic [IDX_W-1:0]  lock_idx_i,
    output logic [IDX_W-1:0]  winner_o,
    output logic              valid_o
);

    logic [IDX_W:0] sum;

    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        sum      = '0;
        if (lock_i) begin
            winner_o = lock_idx_i;
            valid_o  = elig_i[lock_idx_i];
        end else begin
            for (int off = 0; off < NB_REQ; off++) begin
                // rr_ptr_i < NB_REQ, so one conditional subtract wraps the index
                sum = {1'b0, rr_ptr_i} + (IDX_W+1)'(off);
                if (sum >= (IDX_W+1)'(NB_REQ)) sum = sum - (IDX_W+1)'(NB_REQ);
                if (!valid_o && elig_i[sum[IDX_W-1:0]]) begin
                    valid_o  = 1'b1;
                    winner_o = sum[IDX_W-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/per2axi_req_arbiter.sv
// Shares the per2axi request port among NB_REQ requesters with round-robin,
// grant-stable locking, per-requester outstanding limits and atomic serialisation.
module per2axi_req_arbiter
    import per2axi_pkg::*;
#(
    parameter int NB_REQ          = 4,
    parameter int PER_ADDR_WIDTH  = 32,
    parameter int PER_ID_WIDTH    = 5,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NB_REQ-1:0]                     req_i,
    input  logic [NB_REQ-1:0][PER_ADDR_WIDTH-1:0] add_i,
    input  logic [NB_REQ-1:0]                     we_i,
    input  logic [NB_REQ-1:0][5:0]                atop_i,
    input  logic [NB_REQ-1:0][31:0]               wdata_i,
    input  logic [NB_REQ-1:0][3:0]                be_i,
    output logic [NB_REQ-1:0]                     gnt_o,
    output logic                                  per_req_o,
    output logic [PER_ADDR_WIDTH-1:0]             per_add_o,
    output logic                                  per_we_o,
    output logic [5:0]                            per_atop_o,
    output logic [31:0]                           per_wdata_o,
    output logic [3:0]                            per_be_o,
    output logic [PER_ID_WIDTH-1:0]               per_id_o,
    input  logic                                  per_gnt_i,
    input  logic                                  rsp_valid_i,
    input  logic [PER_ID_WIDTH-1:0]               rsp_id_i,
    output logic                                  busy_o,
    output logic                                  err_o
);

    localparam int IDX_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_OUTSTANDING);

    arb_state_e                         state_q, state_d;
    logic [NB_REQ-1:0][CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]                   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]                   lock_idx_q, lock_idx_d;
    logic [IDX_W-1:0]                   atom_id_q, atom_id_d;
    logic                               lock_q, lock_d;
    logic                               err_q, err_d;
    logic [NB_REQ-1:0]                  elig;
    logic [NB_REQ-1:0]                  rsp_hit;
    logic [IDX_W-1:0]                   winner;
    logic                               win_valid;
    logic                               hs;
    logic                               inc, dec;

    // Atomics wait for a fully drained port; nothing issues while one is in flight.
    always_comb begin
        elig = '0;
        for (int k = 0; k < NB_REQ; k++) begin
            elig[k] = req_i[k] && (cnt_q[k] < CNT_MAX) && (state_q == IDLE) &&
                      (!atop_i[k][ATOP_VALID_BIT] || (cnt_q == '0));
        end
    end

    per2axi_rr_arb #(
        .NB_REQ (NB_REQ),
        .IDX_W  (IDX_W)
    ) i_rr_arb (
        .elig_i     (elig),
        .rr_ptr_i   (rr_ptr_q),
        .lock_i     (lock_q),
        .lock_idx_i (lock_idx_q),
        .winner_o   (winner),
        .valid_o    (win_valid)
    );

    // Outputs are gated by reset so they drop asynchronously with it.
    always_comb begin
        per_req_o   = rst_ni & win_valid;
        hs          = per_req_o & per_gnt_i;
        per_add_o   = '0;
        per_we_o    = 1'b0;
        per_atop_o  = '0;
        per_wdata_o = '0;
        per_be_o    = '0;
        per_id_o    = '0;
        gnt_o       = '0;
        if (per_req_o) begin
            per_add_o   = add_i[winner];
            per_we_o    = we_i[winner];
            per_atop_o  = atop_i[winner];
            per_wdata_o = wdata_i[winner];
            per_be_o    = be_i[winner];
            per_id_o    = PER_ID_WIDTH'(1) << winner;
        end
        if (hs) gnt_o[winner] = 1'b1;
    end

    always_comb begin
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        inc     = 1'b0;
        dec     = 1'b0;
        rsp_hit = rsp_id_i[NB_REQ-1:0];
        for (int k = 0; k < NB_REQ; k++) begin
            inc = hs && (winner == IDX_W'(k));
            dec = rsp_valid_i && rsp_hit[k];
            if (dec && (cnt_q[k] == '0)) begin
                err_d = 1'b1;
                if (inc) cnt_d[k] = cnt_q[k] + 1'b1;
            end else if (inc && !dec) begin
                cnt_d[k] = cnt_q[k] + 1'b1;
            end else if (dec && !inc) begin
                cnt_d[k] = cnt_q[k] - 1'b1;
            end
        end
        for (int i = NB_REQ; i < PER_ID_WIDTH; i++) begin
            if (rsp_valid_i && rsp_id_i[i]) err_d = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        lock_d     = per_req_o & ~per_gnt_i;
        lock_idx_d = winner;
        state_d    = state_q;
        atom_id_d  = atom_id_q;
        if (hs) rr_ptr_d = (winner == IDX_W'(NB_REQ - 1)) ? '0 : winner + 1'b1;
        case (state_q)
            IDLE: begin
                if (hs && per_atop_o[ATOP_VALID_BIT]) begin
                    state_d   = ATOMIC;
                    atom_id_d = winner;
                end
            end
            ATOMIC: begin
                if (rsp_valid_i && rsp_hit[atom_id_q] && (cnt_d[atom_id_q] == '0))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            atom_id_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            atom_id_q  <= atom_id_d;
            err_q      <= err_d;
        end
    end

    assign busy_o = (cnt_q != '0) || (state_q == ATOMIC);
    assign err_o  = err_q;

    // A requester left waiting on a stalled port must keep its request unchanged.
    for (genvar k = 0; k < NB_REQ; k++) begin : g_hold
        assume property (@(posedge clk_i) disable iff (!rst_ni)
            (per_req_o && !per_gnt_i && (winner == IDX_W'(k))) |=>
            (req_i[k] && $stable(add_i[k]) && $stable(we_i[k]) && $stable(atop_i[k]) &&
             $stable(wdata_i[k]) && $stable(be_i[k])));
    end

endmodule
